// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bbox_draw frame writer: image size defaults,
// coordinate type, controller state encoding and the outline edge test.
package bbox_pkg;

  localparam int IMG_W_DEF  = 100;
  localparam int IMG_H_DEF  = 100;
  localparam int ADDR_W_DEF = 14;

  typedef logic [15:0] coord_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    CLEAR = 3'd2,
    DRAW  = 3'd3,
    FIN   = 3'd4
  } state_t;

  // True when the pixel lies on the border of the box (x0..x1, y0..y1).
  function automatic logic on_edge(coord_t x, coord_t y, coord_t x0, coord_t x1,
                                   coord_t y0, coord_t y1);
    return (x == x0) || (x == x1) || (y == y0) || (y == y1);
  endfunction

endpackage

// File: rtl/bbox_raster_counter.sv
// Raster walker over an inclusive window: x runs fastest and wraps back to the
// window's left edge. Shared by the clear pass and the box pass.
module bbox_raster_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic        step,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        last
);

  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] xlo_q, xlo_d, xhi_q, xhi_d, yhi_q, yhi_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    xlo_d = xlo_q;
    xhi_d = xhi_q;
    yhi_d = yhi_q;
    if (load) begin
      x_d   = x0;
      y_d   = y0;
      xlo_d = x0;
      xhi_d = x1;
      yhi_d = y1;
    end else if (step) begin
      if (x_q == xhi_q) begin
        x_d = xlo_q;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      xlo_q <= '0;
      xhi_q <= '0;
      yhi_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      xlo_q <= xlo_d;
      xhi_q <= xhi_d;
      yhi_q <= yhi_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xhi_q) && (y_q == yhi_q);

endmodule

// File: rtl/bbox_draw.sv
// Clears the frame RAM, then renders an axis-aligned box into it, one pixel per cycle.
// Outline by default; define BBOX_DRAW_FILL_EN to render a filled rectangle instead.
module bbox_draw
  import bbox_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       xMin,
  input  logic [15:0]       xMax,
  input  logic [15:0]       yMin,
  input  logic [15:0]       yMax,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [2:0]        dbg_state
);

  state_t state_q, state_d;
  coord_t x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic wr_en_q, wr_en_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, pix_addr;

  logic   cnt_load, cnt_step, cnt_last;
  coord_t ld_x0, ld_y0, ld_x1, ld_y1, cnt_x, cnt_y;
  logic   invalid;

  bbox_raster_counter u_cnt (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .load  (cnt_load),
    .x0    (ld_x0),
    .y0    (ld_y0),
    .x1    (ld_x1),
    .y1    (ld_y1),
    .step  (cnt_step),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  assign invalid  = (x0_q > x1_q) || (y0_q > y1_q) ||
                    (int'(x1_q) >= IMG_W) || (int'(y1_q) >= IMG_H);
  assign pix_addr = ADDR_W'(cnt_y) * ADDR_W'(IMG_W) + ADDR_W'(cnt_x);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    ld_x0     = x0_q;
    ld_y0     = y0_q;
    ld_x1     = x1_q;
    ld_y1     = y1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = xMin;
          x1_d    = xMax;
          y0_d    = yMin;
          y1_d    = yMax;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (invalid) begin
          state_d = FIN;
        end else begin
          cnt_load = 1'b1;
          ld_x0    = '0;
          ld_y0    = '0;
          ld_x1    = coord_t'(IMG_W - 1);
          ld_y1    = coord_t'(IMG_H - 1);
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = pix_addr;
        wr_data_d = 1'b0;
        // The last clear pixel reloads the walker with the box window.
        if (cnt_last) begin
          cnt_load = 1'b1;
          state_d  = DRAW;
        end else begin
          cnt_step = 1'b1;
        end
      end
      DRAW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = pix_addr;
`ifdef BBOX_DRAW_FILL_EN
        wr_data_d = 1'b1;
`else
        wr_data_d = on_edge(cnt_x, cnt_y, x0_q, x1_q, y0_q, y1_q);
`endif
        if (cnt_last) state_d = FIN;
        else          cnt_step = 1'b1;
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = invalid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bbox_draw.sv
// Bench for bbox_draw: a frame-RAM model fed by the DUT writes, an expected write
// queue built from the box rules, and bounding-box extraction over the final frame.
module tb_bbox_draw;

  localparam int W    = 100;
  localparam int H    = 100;
  localparam int AW   = 14;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic          busy, done, err, wr_en, wr_data;
  logic [AW-1:0] wr_addr;
  logic [2:0]    dbg_state;

  bbox_draw #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .start    (start),
    .xMin     (x_min),
    .xMax     (x_max),
    .yMin     (y_min),
    .yMax     (y_max),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  logic mem [NPIX];
  logic [AW:0] exp_q[$];

`ifdef BBOX_DRAW_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected write stream: full clear, then the box in raster order.
  task automatic build_expected(input int x0, input int x1, input int y0, input int y1);
    logic [AW-1:0] a;
    logic v;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      a = i[AW-1:0];
      exp_q.push_back({a, 1'b0});
    end
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        int p = y * W + x;
        a = p[AW-1:0];
        v = FILL || (x == x0) || (x == x1) || (y == y0) || (y == y1);
        exp_q.push_back({a, v});
      end
  endtask

  task automatic pulse_start(input int x0, input int x1, input int y0, input int y1,
                             output int k);
    @(negedge clk);
    x_min = x0[15:0]; x_max = x1[15:0]; y_min = y0[15:0]; y_max = y1[15:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
  endtask

  task automatic run_box(input int x0, input int x1, input int y0, input int y1,
                         input bit inject);
    int k, done_cyc, nwr, seq_err, ones, n, bw, bh, exp_ones, exp_lat;
    int bx0, bx1, by0, by1, last_addr, last_data;
    bit valid;
    logic [AW:0] e;
    valid = (x0 <= x1) && (y0 <= y1) && (x1 < W) && (y1 < H);
    bw = x1 - x0 + 1;
    bh = y1 - y0 + 1;
    n  = valid ? bw * bh : 0;
    exp_q.delete();
    if (valid) build_expected(x0, x1, y0, y1);
    for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));

    pulse_start(x0, x1, y0, y1, k);
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("err_cleared", err, 0);

    done_cyc = -1; nwr = 0; seq_err = 0; last_addr = -1; last_data = -1;
    for (int t = 0; t < 20000 && done_cyc < 0; t++) begin
      if (wr_en === 1'b1) begin
        nwr++;
        if (exp_q.size() == 0) seq_err++;
        else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) seq_err++;
        end
        if (int'(wr_addr) < NPIX) mem[wr_addr] = wr_data;
        last_addr = int'(wr_addr);
        last_data = int'(wr_data);
      end
      if (done === 1'b1) done_cyc = cyc;
      if (inject && t == 37) begin
        start = 1'b1; x_min = 16'd5; x_max = 16'd6; y_min = 16'd5; y_max = 16'd6;
      end
      if (inject && t == 38) start = 1'b0;
      if (done_cyc < 0) @(negedge clk);
    end
    seq_err += exp_q.size();

    exp_lat = valid ? 2 + NPIX + n : 2;
    check("done_seen", done_cyc >= 0, 1);
    check("done_latency", done_cyc - k, exp_lat);
    check("err_flag", err, valid ? 0 : 1);
    check("busy_at_done", busy, 0);
    check("write_count", nwr, valid ? NPIX + n : 0);
    check("write_seq_errs", seq_err, 0);

    if (valid) begin
      check("last_write_addr", last_addr, y1 * W + x1);
      check("last_write_data", last_data, 1);
      ones = 0; bx0 = W; bx1 = -1; by0 = H; by1 = -1;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (mem[y * W + x] === 1'b1) begin
            ones++;
            if (x < bx0) bx0 = x;
            if (x > bx1) bx1 = x;
            if (y < by0) by0 = y;
            if (y > by1) by1 = y;
          end
      if (FILL || bw == 1 || bh == 1) exp_ones = n;
      else exp_ones = 2 * bw + 2 * bh - 4;
      check("ram_ones", ones, exp_ones);
      check("bbox_xmin", bx0, x0);
      check("bbox_ymin", by0, y0);
      check("bbox_xmax", bx1, x1);
      check("bbox_ymax", by1, y1);
    end
  endtask

  task automatic run_reset_mid();
    int k;
    pulse_start(10, 20, 10, 20, k);
    for (int t = 0; t < 1000 && cyc < k + 500; t++) @(negedge clk);
    check("mid_clear_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rx0, rx1, ry0, ry1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_box(28, 79, 29, 65, 1'b0);
    run_box(99, 99, 99, 99, 1'b0);
    run_box(0, 0, 0, 0, 1'b0);
    run_box(50, 40, 10, 20, 1'b0);
    run_box(10, 100, 10, 20, 1'b0);

    rx0 = $urandom_range(1, 99);
    rx1 = $urandom_range(0, 99);
    ry0 = $urandom_range(40, 99);
    ry1 = $urandom_range(0, 39);
    run_box(rx1 % 50, rx1 % 50 + 3, ry0, ry1, 1'b0);
    run_box(0, rx0, 0, $urandom_range(H, 65535), 1'b0);

    run_reset_mid();
    run_box(28, 79, 29, 65, 1'b1);

    rx0 = $urandom_range(0, 99);
    rx1 = $urandom_range(rx0, 99);
    ry0 = $urandom_range(0, 99);
    ry1 = $urandom_range(ry0, 99);
    run_box(rx0, rx1, ry0, ry1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
